gmii_rx_framer: RTL and testbench
=================================

GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

Interface
- REQ-001 Parameter MIN_LEN, default 64: minimum legal frame length in bytes, FCS included.
- REQ-002 Parameter MAX_LEN, default 1522: maximum legal frame length in bytes, FCS included.
- REQ-003 Port i_clk, input, 1: GMII receive clock, 125 MHz; the block SHALL use only this clock.
- REQ-004 Port i_rst_n, input, 1: reset, asynchronous assert, active-low.
- REQ-005 Ports i_gmii_dv (input, 1), iv_gmii_rxd (input, 8), i_gmii_er (input, 1): GMII receive signals from the port adapter.
- REQ-006 Port ov_data, output, 8: frame byte with preamble and SFD stripped.
- REQ-007 Port o_data_wr, output, 1: ov_data valid this cycle.
- REQ-008 Ports o_sop and o_eop, outputs, 1 each: first and last frame byte; both are qualified by o_data_wr.
- REQ-009 Ports o_frame_err (output, 1) and ov_frame_len (output, 12): frame status, valid only with o_eop.
- REQ-010 Ports ov_rx_frame_cnt and ov_err_frame_cnt, outputs, 16 each: good-frame and bad-frame counters.

Function
- REQ-011 FSM states: IDLE, PREAMBLE, DATA, DROP.
- REQ-012 IDLE transitions: dv=1 and rxd=8'h55 -> PREAMBLE; dv=1 with any other rxd -> DROP.
- REQ-013 PREAMBLE transitions: rxd=8'h55 -> stay; rxd=8'hD5 -> DATA; any other rxd -> DROP; dv=0 -> IDLE with no output.
- REQ-014 DATA: each cycle with dv=1 accepts one byte; dv=0 -> IDLE.
- REQ-015 DROP: stay while dv=1; dv=0 -> IDLE; no output is produced in DROP.
- REQ-016 Output path: one-byte hold register; each accepted byte SHALL appear on ov_data exactly 1 cycle after acceptance, with o_data_wr=1.
- REQ-017 o_sop marks the first byte after SFD; o_eop marks the byte held when dv falls.
- REQ-018 A 1-byte frame SHALL assert o_sop and o_eop in the same cycle.
- REQ-019 SFD followed immediately by dv=0: no data output; ov_err_frame_cnt increments.
- REQ-020 Length counter: 12 bits, counts accepted bytes, saturates at 4095; ov_frame_len is presented with o_eop.
- REQ-021 o_frame_err=1 when any of these holds: er=1 during DATA with dv=1; length < MIN_LEN; length > MAX_LEN; CRC bad (REQ-029).
- REQ-022 i_gmii_er with dv=0 (carrier extension) SHALL be ignored in every state.
- REQ-023 At o_eop, exactly one counter increments: ov_rx_frame_cnt if o_frame_err=0, otherwise ov_err_frame_cnt.
- REQ-024 Both counters wrap from 16'hFFFF to 0.
- REQ-025 A frame longer than MAX_LEN SHALL still be forwarded in full, flagged by o_frame_err.

Reset
- REQ-026 On reset: FSM=IDLE, hold register empty, and all outputs, counters and the length counter 0.
- REQ-027 After reset release, if dv=1 on the first sampled cycle, the FSM SHALL enter DROP regardless of rxd, so no partial frame is emitted.
- REQ-028 Reset asserted mid-frame SHALL clear outputs immediately and emit no o_eop.

Configuration
- REQ-029 With GMII_RX_CRC_CHECK_EN defined, CRC-32 (IEEE 802.3) runs over all DATA bytes; a frame is CRC-bad when the final residue is not 32'hC704DD7B.
- REQ-030 Without GMII_RX_CRC_CHECK_EN, no CRC logic is built and CRC never contributes to o_frame_err.

Structure
- REQ-031 A shared package holds: FSM state encodings, preamble constant 8'h55, SFD constant 8'hD5, CRC residue 32'hC704DD7B, and the 12-bit length width.
- REQ-032 Sub-module crc32_d8 (combinational, 8-bit data, 32-bit state) is instantiated only under GMII_RX_CRC_CHECK_EN.

Verification
- REQ-033 7x55, D5, 64-byte good frame, dv falls -> 64 o_data_wr pulses, each 1 cycle after its input byte; o_sop on byte 0; o_eop on byte 63; len=64; err=0; ov_rx_frame_cnt=1.
- REQ-034 Same frame with er=1 on byte 10 -> full frame forwarded, o_frame_err=1, ov_err_frame_cnt=1.
- REQ-035 Runt 40-byte frame, then 1600-byte frame -> both have err=1 (len=40, len=1600); ov_err_frame_cnt=2.
- REQ-036 Preamble 55,55,A5,... -> DROP, no o_data_wr until the next valid frame, which is received normally.
- REQ-037 Reset released with dv=1 mid-frame -> no output for that frame; next frame good; dv=0 with er=1 between frames has no effect.
- REQ-038 (CRC enabled) Good 64-byte frame with one FCS bit flipped -> o_frame_err=1; unmodified frame -> o_frame_err=0.

Source files
------------

// File: rtl/gmii_rx_framer_pkg.sv
// Shared types and constants for the GMII receive framer.
package gmii_rx_framer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StDrop
  } state_e;

  localparam logic [7:0]  PreambleByte = 8'h55;
  localparam logic [7:0]  SfdByte      = 8'hD5;
  localparam logic [31:0] CrcResidue   = 32'hC704DD7B;
  localparam int unsigned LenW         = 12;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (IEEE 802.3) step over one byte, bits consumed LSB first,
// register kept in non-reflected (MSB-first) form.
module crc32_d8 (
  input  logic [7:0]  iv_data,
  input  logic [31:0] iv_crc,
  output logic [31:0] ov_crc
);

  localparam logic [31:0] Poly = 32'h04C11DB7;

  logic [31:0] crc_v;
  logic        fb;

  always_comb begin
    crc_v = iv_crc;
    fb    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb    = crc_v[31] ^ iv_data[i];
      crc_v = {crc_v[30:0], 1'b0} ^ (fb ? Poly : 32'h0);
    end
    ov_crc = crc_v;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, delimits frames and keeps frame counters.
// Optional CRC-32 check is built when GMII_RX_CRC_CHECK_EN is defined.
module gmii_rx_framer
  import gmii_rx_framer_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_gmii_dv,
  input  logic [7:0]      iv_gmii_rxd,
  input  logic            i_gmii_er,
  output logic [7:0]      ov_data,
  output logic            o_data_wr,
  output logic            o_sop,
  output logic            o_eop,
  output logic            o_frame_err,
  output logic [LenW-1:0] ov_frame_len,
  output logic [15:0]     ov_rx_frame_cnt,
  output logic [15:0]     ov_err_frame_cnt
);

  localparam logic [LenW-1:0] MinLen = LenW'(MIN_LEN);
  localparam logic [LenW-1:0] MaxLen = LenW'(MAX_LEN);

  state_e          state_q, state_d;
  logic            first_q;
  logic [7:0]      hold_q;
  logic            hold_vld_q, hold_sop_q;
  logic [LenW-1:0] len_q;
  logic            err_q;
  logic [7:0]      data_q;
  logic            wr_q, sop_q, eop_q, frame_err_q;
  logic [LenW-1:0] frame_len_q;
  logic [15:0]     rx_cnt_q, err_cnt_q;

  logic accept, sfd_hit, empty_end, last, crc_bad, frame_bad;

  assign accept    = (state_q == StData) && i_gmii_dv;
  assign sfd_hit   = (state_q == StPreamble) && i_gmii_dv && (iv_gmii_rxd == SfdByte);
  assign empty_end = (state_q == StData) && !i_gmii_dv && (len_q == '0);
  // The held byte is the last one when no further byte is accepted this cycle.
  assign last      = hold_vld_q && !accept;
  assign frame_bad = err_q || (len_q < MinLen) || (len_q > MaxLen) || crc_bad;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // dv already high on the first sampled cycle means we joined mid-frame.
        if (i_gmii_dv) begin
          state_d = (first_q || iv_gmii_rxd != PreambleByte) ? StDrop : StPreamble;
        end
      end
      StPreamble: begin
        if (!i_gmii_dv)                       state_d = StIdle;
        else if (iv_gmii_rxd == SfdByte)      state_d = StData;
        else if (iv_gmii_rxd != PreambleByte) state_d = StDrop;
      end
      StData:  if (!i_gmii_dv) state_d = StIdle;
      StDrop:  if (!i_gmii_dv) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef GMII_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_next;

  crc32_d8 u_crc32_d8 (
    .iv_data (iv_gmii_rxd),
    .iv_crc  (crc_q),
    .ov_crc  (crc_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_q <= '1;
    end else if (sfd_hit) begin
      crc_q <= '1;
    end else if (accept) begin
      crc_q <= crc_next;
    end
  end

  assign crc_bad = (crc_q != CrcResidue);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      first_q     <= 1'b1;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      hold_sop_q  <= 1'b0;
      len_q       <= '0;
      err_q       <= 1'b0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      frame_err_q <= 1'b0;
      frame_len_q <= '0;
      rx_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;

      data_q      <= hold_q;
      wr_q        <= hold_vld_q;
      sop_q       <= hold_vld_q && hold_sop_q;
      eop_q       <= last;
      frame_err_q <= last && frame_bad;
      frame_len_q <= last ? len_q : '0;

      hold_vld_q <= accept;
      if (accept) begin
        hold_q     <= iv_gmii_rxd;
        hold_sop_q <= (len_q == '0);
      end

      if (sfd_hit) begin
        len_q <= '0;
        err_q <= 1'b0;
      end else if (accept) begin
        len_q <= (len_q == '1) ? len_q : len_q + 1'b1;
        err_q <= err_q | i_gmii_er;
      end

      if (last) begin
        if (frame_bad) err_cnt_q <= err_cnt_q + 16'd1;
        else           rx_cnt_q  <= rx_cnt_q + 16'd1;
      end else if (empty_end) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign ov_data          = data_q;
  assign o_data_wr        = wr_q;
  assign o_sop            = sop_q;
  assign o_eop            = eop_q;
  assign o_frame_err      = frame_err_q;
  assign ov_frame_len     = frame_len_q;
  assign ov_rx_frame_cnt  = rx_cnt_q;
  assign ov_err_frame_cnt = err_cnt_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Randomized self-checking bench for gmii_rx_framer with a frame-level reference model.
module tb_gmii_rx_framer;

  localparam int MinLen = 64;
  localparam int MaxLen = 1522;
`ifdef GMII_RX_CRC_CHECK_EN
  localparam bit CrcEn = 1'b1;
`else
  localparam bit CrcEn = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_gmii_dv = 1'b0;
  logic [7:0]  iv_gmii_rxd = 8'h00;
  logic        i_gmii_er = 1'b0;
  logic [7:0]  ov_data;
  logic        o_data_wr, o_sop, o_eop, o_frame_err;
  logic [11:0] ov_frame_len;
  logic [15:0] ov_rx_frame_cnt, ov_err_frame_cnt;

  gmii_rx_framer #(
    .MIN_LEN (MinLen),
    .MAX_LEN (MaxLen)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_gmii_dv        (i_gmii_dv),
    .iv_gmii_rxd      (iv_gmii_rxd),
    .i_gmii_er        (i_gmii_er),
    .ov_data          (ov_data),
    .o_data_wr        (o_data_wr),
    .o_sop            (o_sop),
    .o_eop            (o_eop),
    .o_frame_err      (o_frame_err),
    .ov_frame_len     (ov_frame_len),
    .ov_rx_frame_cnt  (ov_rx_frame_cnt),
    .ov_err_frame_cnt (ov_err_frame_cnt)
  );

  always #4 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    bit          sop;
    bit          eop;
    bit          err;
    logic [11:0] len;
    logic [15:0] good;
    logic [15:0] bad;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_good = 0, m_bad = 0;
  int          n_cmp = 0, n_bad = 0;
  int          last_len = -1, last_err = -1, last_sop = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] crc32_ref(input logic [7:0] b[$], input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // One compare process: every cycle an output is either expected by the model or must be idle.
  exp_t ce;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      ce = exp_q.pop_front();
      check("data_wr", o_data_wr, 1);
      check("data", ov_data, ce.data);
      check("sop", o_sop, ce.sop);
      check("eop", o_eop, ce.eop);
      if (ce.eop) begin
        check("frame_len", ov_frame_len, ce.len);
        check("frame_err", o_frame_err, ce.err);
        check("rx_frame_cnt@eop", ov_rx_frame_cnt, ce.good);
        check("err_frame_cnt@eop", ov_err_frame_cnt, ce.bad);
        last_len = ov_frame_len;
        last_err = o_frame_err;
        last_sop = o_sop;
      end
    end else begin
      check("idle_data_wr", o_data_wr, 0);
    end
  end

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge i_clk);
    #1;
    i_gmii_dv   = dv;
    iv_gmii_rxd = d;
    i_gmii_er   = er;
  endtask

  task automatic gap(input int g, input bit ext);
    for (int i = 0; i < g; i++) drive(1'b0, 8'($urandom), ext ? 1'($urandom_range(0, 1)) : 1'b0);
    if (g >= 3) begin
      check("rx_frame_cnt", ov_rx_frame_cnt, m_good);
      check("err_frame_cnt", ov_err_frame_cnt, m_bad);
    end
  endtask

  // npre preamble bytes, SFD, nbytes data (last 4 are FCS when nbytes>=4).
  task automatic send_frame(input int npre, input int nbytes, input int er_idx, input bit flip,
                            input int bad_at);
    logic [7:0]  fr[$];
    logic [31:0] fcs;
    bit          err;
    bit          good_pre;
    exp_t        e;
    good_pre = (bad_at < 0);
    for (int i = 0; i < nbytes; i++) fr.push_back(8'($urandom));
    if (nbytes >= 4) begin
      fcs = crc32_ref(fr, nbytes - 4);
      if (flip) fcs ^= 32'h1 << $urandom_range(31, 0);
      for (int k = 0; k < 4; k++) fr[nbytes - 4 + k] = fcs[8*k +: 8];
    end
    err = (er_idx >= 0 && er_idx < nbytes) || nbytes < MinLen || nbytes > MaxLen;
    if (CrcEn) begin
      if (nbytes < 4) err = 1'b1;
      else if (crc32_ref(fr, nbytes - 4) !=
               {fr[nbytes-1], fr[nbytes-2], fr[nbytes-3], fr[nbytes-4]}) err = 1'b1;
    end
    if (good_pre) begin
      if (nbytes == 0 || err) m_bad++;
      else                    m_good++;
    end
    for (int i = 0; i < npre; i++) drive(1'b1, (i == bad_at) ? 8'hA5 : 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < nbytes; i++) begin
      drive(1'b1, fr[i], i == er_idx);
      if (good_pre) begin
        e.cyc  = cyc + 2;
        e.data = fr[i];
        e.sop  = (i == 0);
        e.eop  = (i == nbytes - 1);
        e.err  = err;
        e.len  = (nbytes > 4095) ? 12'hFFF : 12'(nbytes);
        e.good = m_good;
        e.bad  = m_bad;
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] str[$];
    int         b0;

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_data", ov_data, 0);
    check("rst_data_wr", o_data_wr, 0);
    check("rst_sop", o_sop, 0);
    check("rst_eop", o_eop, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_frame_len", ov_frame_len, 0);
    check("rst_rx_cnt", ov_rx_frame_cnt, 0);
    check("rst_err_cnt", ov_err_frame_cnt, 0);
    i_rst_n = 1'b1;
    gap(4, 1'b0);

    str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_model_pin", crc32_ref(str, 9), 32'hCBF43926);

    send_frame(7, 64, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("good64_len", last_len, 64);
    check("good64_err", last_err, 0);
    check("good64_rx_cnt", ov_rx_frame_cnt, 1);
    check("good64_err_cnt", ov_err_frame_cnt, 0);

    last_err = -1;
    send_frame(7, 64, 10, 1'b0, -1);
    gap(4, 1'b0);
    check("er_frame_err", last_err, 1);
    check("er_frame_err_cnt", ov_err_frame_cnt, 1);

    send_frame(7, 40, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("runt_len", last_len, 40);
    check("runt_err", last_err, 1);
    send_frame(7, 1600, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("long_len", last_len, 1600);
    check("long_err", last_err, 1);
    check("long_err_cnt", ov_err_frame_cnt, 3);

    send_frame(3, 64, -1, 1'b0, 2);
    gap(4, 1'b1);
    send_frame(7, 64, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("after_badpre_rx_cnt", ov_rx_frame_cnt, 2);

    send_frame(5, 0, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("sfd_only_err_cnt", ov_err_frame_cnt, 4);

    last_sop = -1;
    send_frame(3, 1, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("one_byte_sop_eop", last_sop, 1);
    check("one_byte_len", last_len, 1);
    check("one_byte_err", last_err, 1);

    last_err = -1;
    send_frame(7, 64, -1, 1'b1, -1);
    gap(4, 1'b0);
    check("fcs_flip_err", last_err, 32'(CrcEn));
    last_err = -1;
    send_frame(7, 64, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("fcs_ok_err", last_err, 0);

    send_frame(7, 4100, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("sat_len", last_len, 4095);
    check("sat_err", last_err, 1);

    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    gap(4, 1'b1);

    for (int f = 0; f < 40; f++) begin
      int kind, n, er_idx;
      kind   = $urandom_range(0, 9);
      n      = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 80) : $urandom_range(60, 200);
      er_idx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      case (kind)
        0:       send_frame($urandom_range(1, 7), n, -1, 1'b0, 0);
        1:       send_frame(7, n, -1, 1'b0, $urandom_range(1, 6));
        2:       send_frame($urandom_range(1, 7), 0, -1, 1'b0, -1);
        default: send_frame($urandom_range(1, 7), n, er_idx, $urandom_range(0, 7) == 0, -1);
      endcase
      gap($urandom_range(1, 6), 1'b1);
    end
    gap(4, 1'b0);

    // Reset in the middle of a frame while a byte is on the output.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      b0 = $urandom_range(0, 255);
      drive(1'b1, 8'(b0), 1'b0);
      if (i < 3) exp_q.push_back('{cyc + 2, 8'(b0), i == 0, 1'b0, 1'b0, 12'h0, 16'h0, 16'h0});
    end
    drive(1'b1, 8'h11, 1'b0);
    #1;
    i_rst_n = 1'b0;
    #1;
    m_good = 0;
    m_bad  = 0;
    check("midrst_data_wr", o_data_wr, 0);
    check("midrst_data", ov_data, 0);
    check("midrst_sop", o_sop, 0);
    check("midrst_eop", o_eop, 0);
    check("midrst_rx_cnt", ov_rx_frame_cnt, 0);
    check("midrst_err_cnt", ov_err_frame_cnt, 0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    #1;
    i_rst_n = 1'b1;
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 8'($urandom), 1'b1);
    check("join_midframe_rx_cnt", ov_rx_frame_cnt, 0);
    check("join_midframe_err_cnt", ov_err_frame_cnt, 0);
    send_frame(7, 64, -1, 1'b0, -1);
    gap(4, 1'b1);
    check("post_rst_rx_cnt", ov_rx_frame_cnt, 1);
    check("post_rst_err", last_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
